fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction ROM (imemory).
- Holds the PC and drives the ROM word address; the ROM returns the instruction combinationally in the same cycle.
- Registers PC, instruction and status into the IF/ID pipeline register for decode.
- Handles stall, flush, branch redirect, exception redirect and fetch faults.

---
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID pipeline register. Handles stall, flush, branch and
// exception redirects, and parks in FAULT_HOLD after a fetch fault.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | sequential fetch, one IF/ID load per unstalled cycle
// FAULT_HOLD | a fault was loaded; PC frozen, bubbles until a redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0200,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        exception_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_inst_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o,
    output logic        if_id_fault_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [0:0]  ST_RUN        = 1'b0;
    localparam logic [0:0]  ST_FAULT_HOLD = 1'b1;
    localparam logic [31:0] DEPTH_W       = 32'(IMEM_DEPTH);

    logic [31:0] r_pc;
    logic [0:0]  r_state;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        r_if_valid;
    logic        r_if_fault;
    logic [31:0] r_fetch_count;

    logic        w_fault;
    logic        w_redirect;
    logic        w_bubble;

    // Word address and fault detection derive purely from the current PC.
    always_comb begin
        imem_addr_o = {2'b00, r_pc[31:2]};
        w_fault     = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= DEPTH_W);
        w_redirect  = exception_i || branch_taken_i;
        w_bubble    = w_redirect || flush_i;
    end

    // PC and FSM: redirects beat stall; a fault in RUN freezes the PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_state <= ST_RUN;
        end else if (exception_i) begin
            r_pc    <= EXC_VECTOR;
            r_state <= ST_RUN;
        end else if (branch_taken_i) begin
            r_pc    <= branch_target_i;
            r_state <= ST_RUN;
        end else if (stall_i || (r_state == ST_FAULT_HOLD)) begin
            r_pc    <= r_pc;
        end else if (!w_fault) begin
            r_pc    <= r_pc + 32'd4;
        end else begin
            r_state <= ST_FAULT_HOLD;
        end
    end

    // IF/ID register: bubbles on redirect/flush, hold on stall, else load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_pc       <= 32'h0;
            r_if_inst     <= NOP_INST;
            r_if_valid    <= 1'b0;
            r_if_fault    <= 1'b0;
            r_fetch_count <= 32'h0;
        end else if (w_bubble || (!stall_i && (r_state == ST_FAULT_HOLD))) begin
            r_if_pc       <= 32'h0;
            r_if_inst     <= NOP_INST;
            r_if_valid    <= 1'b0;
            r_if_fault    <= 1'b0;
        end else if (stall_i) begin
            r_if_valid    <= r_if_valid;
        end else if (w_fault) begin
            r_if_pc       <= r_pc;
            r_if_inst     <= NOP_INST;
            r_if_valid    <= 1'b1;
            r_if_fault    <= 1'b1;
        end else begin
            r_if_pc       <= r_pc;
            r_if_inst     <= imem_inst_i;
            r_if_valid    <= 1'b1;
            r_if_fault    <= 1'b0;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign if_id_pc_o    = r_if_pc;
    assign if_id_inst_o  = r_if_inst;
    assign if_id_valid_o = r_if_valid;
    assign if_id_fault_o = r_if_fault;
    assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each step drives inputs, pushes the
// expected post-edge state to a scoreboard queue, then pops and checks it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, flush_i, branch_taken_i, exception_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o, imem_inst_i;
    logic [31:0] if_id_pc_o, if_id_inst_o, fetch_count_o;
    logic        if_id_valid_o, if_id_fault_o;

    logic [31:0] rom [0:1023];

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .exception_i    (exception_i),
        .imem_addr_o    (imem_addr_o),
        .imem_inst_i    (imem_inst_i),
        .if_id_pc_o     (if_id_pc_o),
        .if_id_inst_o   (if_id_inst_o),
        .if_id_valid_o  (if_id_valid_o),
        .if_id_fault_o  (if_id_fault_o),
        .fetch_count_o  (fetch_count_o)
    );

    always #5 clk = ~clk;

    assign imem_inst_i = (imem_addr_o < 32'd1024) ? rom[imem_addr_o[9:0]] : 32'hDEAD_BEEF;

    task automatic chk32(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    task automatic step(input string tag, input logic rs, input logic st, input logic fl,
                        input logic br, input logic [31:0] tg, input logic ex,
                        input logic [31:0] e_addr, input logic [31:0] e_pc, input logic [31:0] e_inst,
                        input logic e_v, input logic e_f, input logic [31:0] e_cnt);
        exp_t e;
        reset = rs; stall_i = st; flush_i = fl;
        branch_taken_i = br; branch_target_i = tg; exception_i = ex;
        e.tag = tag; e.addr = e_addr; e.pc = e_pc; e.inst = e_inst;
        e.valid = e_v; e.fault = e_f; e.cnt = e_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk32(e.tag, "addr",  imem_addr_o,          e.addr);
            chk32(e.tag, "pc",    if_id_pc_o,           e.pc);
            chk32(e.tag, "inst",  if_id_inst_o,         e.inst);
            chk32(e.tag, "valid", {31'b0, if_id_valid_o}, {31'b0, e.valid});
            chk32(e.tag, "fault", {31'b0, if_id_fault_o}, {31'b0, e.fault});
            chk32(e.tag, "cnt",   fetch_count_o,        e.cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0A00_0000 | 32'(i);
        rom[0] = 32'h0021_80B3;
        rom[1] = 32'h0020_80B3;
        reset = 1'b1; stall_i = 0; flush_i = 0; branch_taken_i = 0;
        branch_target_i = 0; exception_i = 0;
        @(negedge clk);

        //     tag            rs st fl br target          ex  addr      if_pc         inst           v  f  cnt
        step("reset",        1, 0, 0, 0, 32'h0,         0, 32'h0,   32'h0,        32'h13,        0, 0, 0);
        step("fetch0",       0, 0, 0, 0, 32'h0,         0, 32'h1,   32'h0,        32'h002180B3,  1, 0, 1);
        step("fetch1",       0, 0, 0, 0, 32'h0,         0, 32'h2,   32'h4,        32'h002080B3,  1, 0, 2);
        step("stall_a",      0, 1, 0, 0, 32'h0,         0, 32'h2,   32'h4,        32'h002080B3,  1, 0, 2);
        step("stall_b",      0, 1, 0, 0, 32'h0,         0, 32'h2,   32'h4,        32'h002080B3,  1, 0, 2);
        step("resume",       0, 0, 0, 0, 32'h0,         0, 32'h3,   32'h8,        32'h0A000002,  1, 0, 3);
        step("br_stall",     0, 1, 0, 1, 32'h40,        0, 32'h10,  32'h0,        32'h13,        0, 0, 3);
        step("br_load",      0, 0, 0, 0, 32'h0,         0, 32'h11,  32'h40,       32'h0A000010,  1, 0, 4);
        step("br_misal",     0, 0, 0, 1, 32'h42,        0, 32'h10,  32'h0,        32'h13,        0, 0, 4);
        step("misal_fault",  0, 0, 0, 0, 32'h0,         0, 32'h10,  32'h42,       32'h13,        1, 1, 4);
        step("hold_a",       0, 0, 0, 0, 32'h0,         0, 32'h10,  32'h0,        32'h13,        0, 0, 4);
        step("hold_b",       0, 0, 0, 0, 32'h0,         0, 32'h10,  32'h0,        32'h13,        0, 0, 4);
        step("exc",          0, 0, 0, 0, 32'h0,         1, 32'h80,  32'h0,        32'h13,        0, 0, 4);
        step("exc_load",     0, 0, 0, 0, 32'h0,         0, 32'h81,  32'h200,      32'h0A000080,  1, 0, 5);
        step("br_ff8",       0, 0, 0, 1, 32'hFF8,       0, 32'h3FE, 32'h0,        32'h13,        0, 0, 5);
        step("idx1022",      0, 0, 0, 0, 32'h0,         0, 32'h3FF, 32'hFF8,      32'h0A0003FE,  1, 0, 6);
        step("idx1023",      0, 0, 0, 0, 32'h0,         0, 32'h400, 32'hFFC,      32'h0A0003FF,  1, 0, 7);
        step("stall_fault",  0, 1, 0, 0, 32'h0,         0, 32'h400, 32'hFFC,      32'h0A0003FF,  1, 0, 7);
        step("idx1024",      0, 0, 0, 0, 32'h0,         0, 32'h400, 32'h1000,     32'h13,        1, 1, 7);
        step("hold_c",       0, 0, 0, 0, 32'h0,         0, 32'h400, 32'h0,        32'h13,        0, 0, 7);
        step("exc2",         0, 0, 0, 0, 32'h0,         1, 32'h80,  32'h0,        32'h13,        0, 0, 7);
        step("flush",        0, 0, 1, 0, 32'h0,         0, 32'h81,  32'h0,        32'h13,        0, 0, 7);
        step("post_flush",   0, 0, 0, 0, 32'h0,         0, 32'h82,  32'h204,      32'h0A000081,  1, 0, 8);
        step("stall_flush",  0, 1, 1, 0, 32'h0,         0, 32'h82,  32'h0,        32'h13,        0, 0, 8);
        step("post_sf",      0, 0, 0, 0, 32'h0,         0, 32'h83,  32'h208,      32'h0A000082,  1, 0, 9);
        step("reset_mid",    1, 1, 0, 0, 32'h0,         1, 32'h0,   32'h0,        32'h13,        0, 0, 0);
        step("after_reset",  0, 0, 0, 0, 32'h0,         0, 32'h1,   32'h0,        32'h002180B3,  1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
